// File: rtl/i2c_tgt_pkg.sv
// Shared types and defaults for the I2C register-port target.
package i2c_tgt_pkg;

  localparam int DEV_ADDR_W     = 7;
  localparam int FILTER_LEN_DEF = 3;
  localparam logic [DEV_ADDR_W-1:0] DEV_ADDR_DEF = 7'h3C;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEVADR,
    ST_DEVACK,
    ST_REGADR,
    ST_REGACK,
    ST_WRDAT,
    ST_WRACK,
    ST_RDDAT,
    ST_RDACK,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_tgt_filter.sv
// Synchronises and de-glitches SCL/SDA together, then derives SCL edges and START/STOP
// from one consistent pair of filtered samples.
module i2c_tgt_filter
  import i2c_tgt_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    scl_sync_q, sda_sync_q;
  logic          scl_f_q, sda_f_q, scl_f_d, sda_f_d;
  logic          scl_p_q, sda_p_q;
  logic [CW-1:0] scl_cnt_q, sda_cnt_q, scl_cnt_d, sda_cnt_d;

  // A line's filtered value follows the synchronised input only after it has
  // disagreed for FILTER_LEN consecutive cycles.
  always_comb begin
    scl_f_d   = scl_f_q;
    scl_cnt_d = '0;
    if (scl_sync_q[1] != scl_f_q) begin
      if (scl_cnt_q == CW'(FILTER_LEN - 1)) scl_f_d = scl_sync_q[1];
      else                                  scl_cnt_d = scl_cnt_q + CW'(1);
    end
    sda_f_d   = sda_f_q;
    sda_cnt_d = '0;
    if (sda_sync_q[1] != sda_f_q) begin
      if (sda_cnt_q == CW'(FILTER_LEN - 1)) sda_f_d = sda_sync_q[1];
      else                                  sda_cnt_d = sda_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
    end
  end

  assign sda_o      = sda_f_q;
  assign scl_rise_o = scl_f_q & ~scl_p_q;
  assign scl_fall_o = ~scl_f_q & scl_p_q;
  assign start_o    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_o     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

endmodule

// File: rtl/i2c_target_regport.sv
// I2C target exposing an 8-bit register port; SDA is open-drain via sda_oe.
// Define I2C_TGT_AUTOINC_EN to auto-increment reg_addr after every written or read byte.
module i2c_target_regport
  import i2c_tgt_pkg::*;
#(
  parameter logic [DEV_ADDR_W-1:0] DEV_ADDR   = DEV_ADDR_DEF,
  parameter int                    FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output state_e     state_o
);

  logic sda_f, scl_rise, scl_fall, start, stop;

  i2c_tgt_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_f),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rw_q, rw_d, ack_q, ack_d, oe_q, oe_d, busy_q, busy_d;
  logic       we_q, we_d, re_q, re_d, rd_pend_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    ack_d   = ack_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
`ifdef I2C_TGT_AUTOINC_EN
    if (we_q) addr_d = addr_q + 8'd1;
`endif
    if (stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = ST_DEVADR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_DEVADR, ST_REGADR, ST_WRDAT: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_f};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            oe_d  = 1'b1;
            if (state_q == ST_DEVADR) begin
              // General call (address 0) is never acknowledged.
              if (shift_q[7:1] == DEV_ADDR && DEV_ADDR != '0) begin
                state_d = ST_DEVACK;
                rw_d    = shift_q[0];
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
                oe_d    = 1'b0;
              end
            end else if (state_q == ST_REGADR) begin
              state_d = ST_REGACK;
              addr_d  = shift_q;
            end else begin
              state_d = ST_WRACK;
              wdata_d = shift_q;
              we_d    = 1'b1;
            end
          end
        end
        ST_DEVACK: if (scl_fall) begin
          oe_d    = 1'b0;
          state_d = rw_q ? ST_RDDAT : ST_REGADR;
          re_d    = rw_q;
        end
        ST_REGACK, ST_WRACK: if (scl_fall) begin
          oe_d    = 1'b0;
          state_d = ST_WRDAT;
        end
        ST_RDDAT: begin
          // Fabric answers reg_re one cycle late; the byte loads while SCL is still low.
          if (rd_pend_q) begin
            shift_d = reg_rdata;
            oe_d    = ~reg_rdata[7];
            cnt_d   = '0;
          end else if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = '0;
              state_d = ST_RDACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        ST_RDACK: begin
          if (scl_rise) begin
            ack_d = ~sda_f;
          end else if (scl_fall) begin
`ifdef I2C_TGT_AUTOINC_EN
            addr_d = addr_q + 8'd1;
`endif
            state_d = ack_q ? ST_RDDAT : ST_IGNORE;
            re_d    = ack_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      ack_q     <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      ack_q     <= ack_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      rd_pend_q <= re_q;
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
  assign state_o   = state_q;

endmodule
